// File: rtl/winograd_output_transform_pkg.sv
// Shared types and constants for the Winograd output transform.
package winograd_output_transform_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS1 = 2'd1,
        ST_PASS2 = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    // MODE_F2: F(2x2,3x3), 4x4 tile -> 2x2 result.
    // MODE_F4: F(4x4,3x3), 6x6 tile -> 4x4 result.
    typedef enum logic {
        MODE_F2 = 1'b0,
        MODE_F4 = 1'b1
    } mode_t;

    // Largest two-pass gain is 19*19 = 361 < 2^9, so 10 guard bits
    // keep the full-width intermediate exact.
    localparam int GUARD_W = 10;

    localparam int AT_F4 [4][6] = '{
        '{1, 1,  1, 1,  1, 0},
        '{0, 1, -1, 2, -2, 0},
        '{0, 1,  1, 4,  4, 0},
        '{0, 1, -1, 8, -8, 1}
    };

    localparam int AT_F2 [2][4] = '{
        '{1, 1,  1,  0},
        '{0, 1, -1, -1}
    };

    // A^T coefficient; zero outside the active rows/columns of the mode.
    function automatic int at_coef(input mode_t mode, input int row, input int col);
        int c;
        c = 0;
        if (mode == MODE_F4) begin
            if (row < 4 && col < 6) c = AT_F4[row[1:0]][col[2:0]];
        end else begin
            if (row < 2 && col < 4) c = AT_F2[row[0]][col[1:0]];
        end
        return c;
    endfunction

endpackage

// File: rtl/winograd_output_transform_if.sv
// Tile in / result out handshake bundle for the Winograd output transform.
interface winograd_output_transform_if #(
    parameter int DATA_W = 40
) ();
    logic                     in_valid;
    logic                     in_ready;
    logic                     mode;
    logic signed [DATA_W-1:0] M [6][6];
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] R [4][4];
    logic                     sat;
    logic                     busy;

    modport master (
        output in_valid, mode, M, out_ready,
        input  in_ready, out_valid, R, sat, busy
    );

    modport slave (
        input  in_valid, mode, M, out_ready,
        output in_ready, out_valid, R, sat, busy
    );
endinterface

// File: rtl/winograd_output_transform_at_1d.sv
// Combinational 1-D output transform: y = A^T * v for one column or row.
module winograd_at_1d
    import winograd_output_transform_pkg::*;
#(
    parameter int IW = 50
) (
    input  mode_t                mode,
    input  logic signed [IW-1:0] vec_in  [6],
    output logic signed [IW-1:0] vec_out [4]
);

    // Constant-coefficient dot products; unused taps have coefficient 0.
    always_comb begin : dot
        logic signed [IW-1:0] acc;
        logic signed [IW-1:0] coef;
        for (int i = 0; i < 4; i++) begin
            acc = '0;
            for (int j = 0; j < 6; j++) begin
                coef = IW'(at_coef(mode, i, j));
                acc  = acc + vec_in[j] * coef;
            end
            vec_out[i] = acc;
        end
    end

endmodule

// File: rtl/winograd_output_transform.sv
// Winograd output transform R = A^T * M * A: columns through the shared
// 1-D transform into a full-width store, then rows into the narrowed R.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | waiting for a tile, in_ready high
// ST_PASS1 | one tile column per cycle into the intermediate
// ST_PASS2 | one intermediate row per cycle into R
// ST_OUT   | result presented until out_ready
module winograd_output_transform
    import winograd_output_transform_pkg::*;
#(
    parameter int DATA_W   = 40,
    parameter bit SATURATE = 1'b0
) (
    input logic clk,
    input logic rst_n,
    winograd_output_transform_if.slave bus
);
    localparam int IW = DATA_W + GUARD_W;
    localparam logic signed [IW-1:0] MAX_V = {{(GUARD_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [IW-1:0] MIN_V = ~MAX_V;

    state_t                   state;
    logic [2:0]               cnt;
    mode_t                    mode_q;
    logic signed [DATA_W-1:0] tile  [6][6];
    logic signed [IW-1:0]     inter [4][6];
    logic signed [IW-1:0]     vec_in  [6];
    logic signed [IW-1:0]     vec_out [4];
    logic signed [DATA_W-1:0] narrow_v [4];
    logic [3:0]               narrow_flag;
    logic [2:0]               last_col;
    logic [2:0]               last_row;

    assign last_col = (mode_q == MODE_F4) ? 3'd5 : 3'd3;
    assign last_row = (mode_q == MODE_F4) ? 3'd3 : 3'd1;

    // Shared transform input: tile column in PASS1, intermediate row in PASS2.
    always_comb begin
        for (int j = 0; j < 6; j++) vec_in[j] = '0;
        if (state == ST_PASS2) begin
            for (int j = 0; j < 6; j++) vec_in[j] = inter[cnt[1:0]][j];
        end else begin
            for (int j = 0; j < 6; j++) vec_in[j] = IW'(tile[j][cnt]);
        end
    end

    winograd_at_1d #(.IW(IW)) u_at_1d (
        .mode    (mode_q),
        .vec_in  (vec_in),
        .vec_out (vec_out)
    );

    // Narrow each full-width row result to DATA_W, flagging out-of-range values.
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            narrow_flag[j] = (vec_out[j] > MAX_V) || (vec_out[j] < MIN_V);
            narrow_v[j]    = vec_out[j][DATA_W-1:0];
            if (SATURATE && (vec_out[j] > MAX_V)) narrow_v[j] = MAX_V[DATA_W-1:0];
            if (SATURATE && (vec_out[j] < MIN_V)) narrow_v[j] = MIN_V[DATA_W-1:0];
        end
    end

    // Sequencer, tile/intermediate storage and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            mode_q        <= MODE_F2;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.sat       <= 1'b0;
            for (int i = 0; i < 6; i++)
                for (int j = 0; j < 6; j++) tile[i][j] <= '0;
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 6; j++) inter[i][j] <= '0;
                for (int j = 0; j < 4; j++) bus.R[i][j] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    bus.in_ready <= 1'b1;
                    if (bus.in_valid && bus.in_ready) begin
                        tile         <= bus.M;
                        mode_q       <= mode_t'(bus.mode);
                        cnt          <= '0;
                        bus.sat      <= 1'b0;
                        bus.in_ready <= 1'b0;
                        bus.busy     <= 1'b1;
                        for (int i = 0; i < 4; i++)
                            for (int j = 0; j < 4; j++) bus.R[i][j] <= '0;
                        state        <= ST_PASS1;
                    end
                end
                ST_PASS1: begin
                    for (int k = 0; k < 4; k++) inter[k][cnt] <= vec_out[k];
                    if (cnt == last_col) begin
                        cnt   <= '0;
                        state <= ST_PASS2;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                ST_PASS2: begin
                    for (int j = 0; j < 4; j++) begin
                        if (3'(j) <= last_row) begin
                            bus.R[cnt[1:0]][j] <= narrow_v[j];
                            if (narrow_flag[j]) bus.sat <= 1'b1;
                        end
                    end
                    if (cnt == last_row) begin
                        cnt   <= '0;
                        state <= ST_OUT;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                ST_OUT: begin
                    if (!bus.out_valid) begin
                        bus.out_valid <= 1'b1;
                    end else if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.busy      <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/winograd_output_transform.md
WINOGRAD_OUTPUT_TRANSFORM -- requirements
Module: winograd_output_transform

Interface
REQ-001 Parameter DATA_W, default 40, signed element width of input tile and result.
REQ-002 Parameter SATURATE, default 0; 0 = two's-complement wrap to DATA_W, 1 = clamp to DATA_W range.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  tile M and mode are presented.
REQ-006 in_ready  output  1  block accepts a tile this cycle.
REQ-007 mode  input  1  0 = F(2x2,3x3), 4x4 tile to 2x2 result; 1 = F(4x4,3x3), 6x6 tile to 4x4 result.
REQ-008 M  input  6x6xDATA_W signed  tile; mode 0 uses M[0..3][0..3] only.
REQ-009 out_valid  output  1  R is valid.
REQ-010 out_ready  input  1  consumer takes R.
REQ-011 R  output  4x4xDATA_W signed  result; mode 0 fills R[0..1][0..1].
REQ-012 sat  output  1  at least one R element of the current result clamped or wrapped.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 Compute R = A^T * M * A in two passes using one shared 1-D transform; pass 1 columns, pass 2 rows.
REQ-015 A^T mode 0 rows: [1 1 1 0], [0 1 -1 -1].
REQ-016 A^T mode 1 rows: [1 1 1 1 1 0], [0 1 -1 2 -2 0], [0 1 1 4 4 0], [0 1 -1 8 -8 1].
REQ-017 States: IDLE, PASS1, PASS2, OUT.
REQ-018 in_ready = 1 only in IDLE.
REQ-019 Acceptance occurs on in_valid & in_ready; M and mode are copied into an internal tile register on that edge. Upstream may change M afterwards.
REQ-020 PASS1 runs T cycles (T = 4 mode 0, T = 6 mode 1), one column per cycle.
REQ-021 PASS2 runs Mo cycles (Mo = 2 mode 0, Mo = 4 mode 1), one row per cycle.
REQ-022 OUT is entered after the last PASS2 cycle; out_valid rises T+Mo+1 edges after the accepting edge (11 mode 1, 7 mode 0).
REQ-023 out_valid holds, and R and sat stay stable, until out_valid & out_ready; that edge returns the block to IDLE.
REQ-024 There is no same-cycle bypass: in_ready is first high the cycle after the output handshake.
REQ-025 Internal arithmetic is at DATA_W+10 bits. The intermediate is stored at full width, and narrowing happens only on the final R write.
REQ-026 Narrowing with SATURATE=1 clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. With SATURATE=0 it keeps the low DATA_W bits.
REQ-027 sat clears at acceptance and sets if any written element's value differs from its full-width value.
REQ-028 In mode 0, unused R elements read 0 while out_valid is high.
REQ-029 out_ready while out_valid is low has no effect; in_valid outside IDLE is ignored.

Reset
REQ-030 rst_n low forces IDLE; in_ready=0 during reset and 1 after; out_valid=0, busy=0, sat=0, R=0, counters 0.
REQ-031 Reset asserted mid-PASS1, PASS2 or OUT abandons the tile; no out_valid follows.

Structure
REQ-032 A shared package holds the state enum, mode encoding, guard-bit constant 10 and A^T coefficient tables.
REQ-033 One sub-module, winograd_at_1d, is combinational: it takes a 6-element vector at DATA_W+10 bits plus mode and returns 4 elements. Inputs at index 4..5 are ignored in mode 0.
REQ-034 Top level holds the FSM, counter, tile register, intermediate 4x6 store, narrowing and R register.

Verification
REQ-035 Mode 1, DATA_W=40, M all 1: accept at edge 0, out_valid at edge 11; R row0=[25,0,50,5], R[2][2]=100, R[3][3]=1, sat=0.
REQ-036 Mode 0, M[0..3][0..3] all 1: out_valid after 7 edges; R[0..1][0..1]=[[9,-3],[-3,1]], other R=0.
REQ-037 DATA_W=8, mode 1, M all 127, SATURATE=1: R[2][2]=127, sat=1. With SATURATE=0: R[2][2]=-100 (12700 mod 256), sat=1.
REQ-038 Hold out_ready=0 for 20 cycles after out_valid: R stable, in_ready=0, and a new in_valid is ignored. out_ready=1 for one cycle, then in_ready=1 the next cycle and the queued tile is accepted.
REQ-039 Assert rst_n=0 at cycle 3 of PASS1: outputs take reset values, and out_valid never rises for that tile. A subsequent tile computes correctly.
REQ-040 Back-to-back alternating mode 1 and mode 0 tiles with random M: every R matches the reference model, with per-mode latency as in REQ-022.
